// File: rtl/csi2_pkg.sv
// Shared types and constants for the CSI-2 multi-VC frame/line tracker.
// Data-type codes, per-VC FSM states and sticky error bit positions.
package csi2_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_LS       = 6'h02;
   localparam logic [5:0] DT_LE       = 6'h03;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;
   localparam logic [5:0] DT_EBD      = 6'h12;
   localparam logic [5:0] DT_PIX_LO   = 6'h18;
   localparam logic [5:0] DT_PIX_HI   = 6'h2F;

   localparam int ERR_ECC   = 0;
   localparam int ERR_CRC   = 1;
   localparam int ERR_PROTO = 2;
   localparam int ERR_TRUNC = 3;
   localparam int ERR_UNSUP = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FRAME,
      ST_LINE,
      ST_EBD
   } vc_state_e;

   typedef enum logic [2:0] {
      DTC_NONE,
      DTC_FS,
      DTC_FE,
      DTC_PIX,
      DTC_EBD,
      DTC_LONG
   } dt_class_e;

   // LS/LE deliberately map to NONE: line timing comes from long packets
   function automatic dt_class_e dt_classify(input logic [5:0] dt);
      dt_class_e c;
      c = DTC_NONE;
      if (dt == DT_FS) begin
         c = DTC_FS;
      end else if (dt == DT_FE) begin
         c = DTC_FE;
      end else if (dt == DT_EBD) begin
         c = DTC_EBD;
      end else if (dt >= DT_PIX_LO && dt <= DT_PIX_HI) begin
         c = DTC_PIX;
      end else if (dt >= DT_LONG_MIN) begin
         c = DTC_LONG;
      end
      return c;
   endfunction

endpackage

// File: rtl/csi2_vc_fsm.sv
// Per-virtual-channel frame/line FSM with line, frame and last-line counters.
// A payload end is applied before a header arriving in the same cycle.
module csi2_vc_fsm
   import csi2_pkg::*;
#(
   parameter int g_CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pend_i,
   input  logic                   fs_i,
   input  logic                   fe_i,
   input  logic                   pix_i,
   input  logic                   ebd_i,
   input  logic [15:0]            wc_i,
   output logic                   frame_valid_o,
   output logic                   line_valid_o,
   output logic                   ebd_valid_o,
   output logic [g_CNT_WIDTH-1:0] frame_cnt_o,
   output logic [g_CNT_WIDTH-1:0] last_lines_o,
   output logic                   wc_mismatch_o,
   output logic                   proto_err_o,
   output logic                   trunc_err_o
);

   vc_state_e              state_q, state_d;
   logic [g_CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
   logic [g_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
   logic [g_CNT_WIDTH-1:0] last_lines_q, last_lines_d;
   logic [15:0]            ref_wc_q, ref_wc_d;
   logic                   ref_ok_q, ref_ok_d;
   logic                   mism_q, mism_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         line_cnt_q   <= '0;
         frame_cnt_q  <= '0;
         last_lines_q <= '0;
         ref_wc_q     <= '0;
         ref_ok_q     <= 1'b0;
         mism_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_cnt_q   <= line_cnt_d;
         frame_cnt_q  <= frame_cnt_d;
         last_lines_q <= last_lines_d;
         ref_wc_q     <= ref_wc_d;
         ref_ok_q     <= ref_ok_d;
         mism_q       <= mism_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      line_cnt_d   = line_cnt_q;
      frame_cnt_d  = frame_cnt_q;
      last_lines_d = last_lines_q;
      ref_wc_d     = ref_wc_q;
      ref_ok_d     = ref_ok_q;
      mism_d       = mism_q;
      proto_err_o  = 1'b0;
      trunc_err_o  = 1'b0;

      if (pend_i) begin
         if (state_q == ST_LINE) begin
            state_d = ST_FRAME;
            if (line_cnt_q != '1) begin
               line_cnt_d = line_cnt_q + 1'b1;
            end
         end else if (state_q == ST_EBD) begin
            state_d = ST_FRAME;
         end
      end

      // header is evaluated against the post-payload-end state
      unique case (1'b1)
         fs_i: begin
            proto_err_o = (state_d != ST_IDLE);
            state_d     = ST_FRAME;
            line_cnt_d  = '0;
            ref_ok_d    = 1'b0;
         end
         fe_i: begin
            if (state_d == ST_FRAME) begin
               frame_cnt_d  = frame_cnt_q + 1'b1;
               last_lines_d = line_cnt_d;
            end else if (state_d != ST_IDLE) begin
               trunc_err_o = 1'b1;
            end
            state_d = ST_IDLE;
         end
         pix_i: begin
            if (state_d == ST_FRAME) begin
               state_d = ST_LINE;
               if (!ref_ok_q) begin
                  ref_wc_d = wc_i;
                  ref_ok_d = 1'b1;
               end else if (wc_i != ref_wc_q) begin
                  mism_d = 1'b1;
               end
            end else begin
               proto_err_o = 1'b1;
            end
         end
         ebd_i: begin
            if (state_d == ST_FRAME) begin
               state_d = ST_EBD;
            end else begin
               proto_err_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign frame_valid_o = (state_q != ST_IDLE);
   assign line_valid_o  = (state_q == ST_LINE);
   assign ebd_valid_o   = (state_q == ST_EBD);
   assign frame_cnt_o   = frame_cnt_q;
   assign last_lines_o  = last_lines_q;
   assign wc_mismatch_o = mism_q;

endmodule

// File: rtl/csi2_vc_frame_tracker.sv
// Multi-VC frame/line tracker behind the CSI-2 RX packet decoder.
// Filters headers, routes events to per-VC FSMs, keeps error state and IRQ.
module csi2_vc_frame_tracker
   import csi2_pkg::*;
#(
   parameter int g_NO_OF_VC      = 4,
   parameter int g_VC_BITS       = 2,
   parameter int g_CNT_WIDTH     = 16,
   parameter int g_ERR_CNT_WIDTH = 8
) (
   input  logic                              PARALLEL_CLOCK_I,
   input  logic                              RESET_I,
   input  logic                              HDR_VALID_I,
   input  logic [g_VC_BITS-1:0]              HDR_VC_I,
   input  logic [5:0]                        HDR_DT_I,
   input  logic [15:0]                       HDR_WC_I,
   input  logic                              HDR_ECC_ERR_I,
   input  logic                              PEND_VALID_I,
   input  logic                              PEND_CRC_ERR_I,
   input  logic [4:0]                        ERR_CLEAR_I,
   input  logic [4:0]                        IRQ_MASK_I,
   output logic [g_NO_OF_VC-1:0]             FRAME_VALID_O,
   output logic [g_NO_OF_VC-1:0]             LINE_VALID_O,
   output logic [g_NO_OF_VC-1:0]             EBD_VALID_O,
   output logic [g_NO_OF_VC*g_CNT_WIDTH-1:0] FRAME_CNT_O,
   output logic [g_NO_OF_VC*g_CNT_WIDTH-1:0] LAST_LINES_O,
   output logic [g_NO_OF_VC-1:0]             WC_MISMATCH_O,
   output logic [g_ERR_CNT_WIDTH-1:0]        ECC_ERR_CNT_O,
   output logic [g_ERR_CNT_WIDTH-1:0]        CRC_ERR_CNT_O,
   output logic [4:0]                        ERR_STICKY_O,
   output logic                              MIPI_INTERRUPT_O
);

   localparam logic [g_VC_BITS:0] NVC = (g_VC_BITS + 1)'(g_NO_OF_VC);

   logic                       act_ok_q, act_ok_d;
   logic [g_VC_BITS-1:0]       act_vc_q, act_vc_d;
   logic [g_ERR_CNT_WIDTH-1:0] ecc_cnt_q, ecc_cnt_d;
   logic [g_ERR_CNT_WIDTH-1:0] crc_cnt_q, crc_cnt_d;
   logic [4:0]                 sticky_q, sticky_d;
   logic                       irq_q, irq_d;

   dt_class_e             dtc;
   logic                  vc_ok;
   logic                  hdr_clean;
   logic                  hdr_ok;
   logic                  hdr_long;
   logic                  pend_hit;
   logic                  ecc_hit;
   logic                  crc_hit;
   logic                  unsup_hit;
   logic [g_NO_OF_VC-1:0] proto_v;
   logic [g_NO_OF_VC-1:0] trunc_v;
   logic [4:0]            err_set;

   assign dtc       = dt_classify(HDR_DT_I);
   assign vc_ok     = ({1'b0, HDR_VC_I} < NVC);
   assign hdr_clean = HDR_VALID_I & ~HDR_ECC_ERR_I;
   assign hdr_ok    = hdr_clean & vc_ok;
   assign hdr_long  = (HDR_DT_I >= DT_LONG_MIN);
   assign pend_hit  = PEND_VALID_I & act_ok_q;
   assign ecc_hit   = HDR_VALID_I & HDR_ECC_ERR_I;
   assign crc_hit   = pend_hit & PEND_CRC_ERR_I;
   assign unsup_hit = hdr_clean & ~vc_ok;

   for (genvar i = 0; i < g_NO_OF_VC; i++) begin : g_vc
      logic sel;
      logic pend_sel;
      assign sel      = hdr_ok & (HDR_VC_I == g_VC_BITS'(i));
      assign pend_sel = pend_hit & (act_vc_q == g_VC_BITS'(i));

      csi2_vc_fsm #(
         .g_CNT_WIDTH(g_CNT_WIDTH)
      ) u_fsm (
         .clk          (PARALLEL_CLOCK_I),
         .rst          (RESET_I),
         .pend_i       (pend_sel),
         .fs_i         (sel & (dtc == DTC_FS)),
         .fe_i         (sel & (dtc == DTC_FE)),
         .pix_i        (sel & (dtc == DTC_PIX)),
         .ebd_i        (sel & (dtc == DTC_EBD)),
         .wc_i         (HDR_WC_I),
         .frame_valid_o(FRAME_VALID_O[i]),
         .line_valid_o (LINE_VALID_O[i]),
         .ebd_valid_o  (EBD_VALID_O[i]),
         .frame_cnt_o  (FRAME_CNT_O[i*g_CNT_WIDTH +: g_CNT_WIDTH]),
         .last_lines_o (LAST_LINES_O[i*g_CNT_WIDTH +: g_CNT_WIDTH]),
         .wc_mismatch_o(WC_MISMATCH_O[i]),
         .proto_err_o  (proto_v[i]),
         .trunc_err_o  (trunc_v[i])
      );
   end

   always_comb begin
      act_ok_d = act_ok_q;
      act_vc_d = act_vc_q;
      if (pend_hit) begin
         act_ok_d = 1'b0;
      end
      // an unsupported long header drops ownership so its payload end is ignored
      if (hdr_clean && hdr_long) begin
         act_ok_d = vc_ok;
         if (vc_ok) begin
            act_vc_d = HDR_VC_I;
         end
      end
   end

   always_comb begin
      ecc_cnt_d = ecc_cnt_q;
      crc_cnt_d = crc_cnt_q;
      if (ecc_hit && ecc_cnt_q != '1) begin
         ecc_cnt_d = ecc_cnt_q + 1'b1;
      end
      if (crc_hit && crc_cnt_q != '1) begin
         crc_cnt_d = crc_cnt_q + 1'b1;
      end

      err_set            = '0;
      err_set[ERR_ECC]   = ecc_hit;
      err_set[ERR_CRC]   = crc_hit;
      err_set[ERR_PROTO] = |proto_v;
      err_set[ERR_TRUNC] = |trunc_v;
      err_set[ERR_UNSUP] = unsup_hit;

      sticky_d = (sticky_q & ~ERR_CLEAR_I) | err_set;
      irq_d    = |(sticky_d & IRQ_MASK_I);
   end

   always_ff @(posedge PARALLEL_CLOCK_I or posedge RESET_I) begin
      if (RESET_I) begin
         act_ok_q  <= 1'b0;
         act_vc_q  <= '0;
         ecc_cnt_q <= '0;
         crc_cnt_q <= '0;
         sticky_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         act_ok_q  <= act_ok_d;
         act_vc_q  <= act_vc_d;
         ecc_cnt_q <= ecc_cnt_d;
         crc_cnt_q <= crc_cnt_d;
         sticky_q  <= sticky_d;
         irq_q     <= irq_d;
      end
   end

   assign ECC_ERR_CNT_O    = ecc_cnt_q;
   assign CRC_ERR_CNT_O    = crc_cnt_q;
   assign ERR_STICKY_O     = sticky_q;
   assign MIPI_INTERRUPT_O = irq_q;

endmodule

// File: tb/tb_csi2_vc_frame_tracker.sv
// Bench for csi2_vc_frame_tracker: directed scenarios plus random traffic,
// each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_csi2_vc_frame_tracker;

   typedef struct packed {
      logic [3:0]  fv;
      logic [3:0]  lv;
      logic [3:0]  ev;
      logic [3:0]  wm;
      logic [63:0] fc;
      logic [63:0] ll;
      logic [7:0]  ecc;
      logic [7:0]  crc;
      logic [4:0]  st;
      logic        irq;
   } snap_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        hv = 1'b0;
   logic [3:0]  hvc = '0;
   logic [5:0]  hdt = '0;
   logic [15:0] hwc = '0;
   logic        hecc = 1'b0;
   logic        pv = 1'b0;
   logic        pcrc = 1'b0;
   logic [4:0]  clr = '0;
   logic [4:0]  mask = '0;

   logic [3:0]  fv_o, lv_o, ev_o, wm_o;
   logic [63:0] fc_o, ll_o;
   logic [7:0]  ecc_o, crc_o;
   logic [4:0]  st_o;
   logic        irq_o;

   csi2_vc_frame_tracker #(
      .g_NO_OF_VC     (4),
      .g_VC_BITS      (4),
      .g_CNT_WIDTH    (16),
      .g_ERR_CNT_WIDTH(8)
   ) dut (
      .PARALLEL_CLOCK_I(clk),
      .RESET_I         (rst),
      .HDR_VALID_I     (hv),
      .HDR_VC_I        (hvc),
      .HDR_DT_I        (hdt),
      .HDR_WC_I        (hwc),
      .HDR_ECC_ERR_I   (hecc),
      .PEND_VALID_I    (pv),
      .PEND_CRC_ERR_I  (pcrc),
      .ERR_CLEAR_I     (clr),
      .IRQ_MASK_I      (mask),
      .FRAME_VALID_O   (fv_o),
      .LINE_VALID_O    (lv_o),
      .EBD_VALID_O     (ev_o),
      .FRAME_CNT_O     (fc_o),
      .LAST_LINES_O    (ll_o),
      .WC_MISMATCH_O   (wm_o),
      .ECC_ERR_CNT_O   (ecc_o),
      .CRC_ERR_CNT_O   (crc_o),
      .ERR_STICKY_O    (st_o),
      .MIPI_INTERRUPT_O(irq_o)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   snap_t exp_q[$];

   // reference model: frame open flag, packet kind (0 none, 1 pixel, 2 ebd)
   bit       m_inf[4];
   int       m_pkt[4];
   int       m_lines[4];
   int       m_ref[4];
   int       m_frames[4];
   int       m_last[4];
   bit       m_wm[4];
   int       m_act;
   int       m_ecc;
   int       m_crc;
   bit [4:0] m_st;
   bit       m_irq;

   logic [5:0] dts[9] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h2B,
                          6'h12, 6'h18, 6'h30, 6'h07};

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         m_inf[v] = 0; m_pkt[v] = 0; m_lines[v] = 0; m_ref[v] = -1;
         m_frames[v] = 0; m_last[v] = 0; m_wm[v] = 0;
      end
      m_act = -1; m_ecc = 0; m_crc = 0; m_st = '0; m_irq = 0;
   endtask

   task automatic model_step();
      bit [4:0] set;
      int vc;
      int dt;
      set = '0;
      if (rst) begin
         model_reset();
         return;
      end
      if (pv && m_act >= 0) begin
         if (pcrc) begin
            if (m_crc < 255) m_crc++;
            set[1] = 1;
         end
         if (m_pkt[m_act] == 1 && m_lines[m_act] < 65535) m_lines[m_act]++;
         m_pkt[m_act] = 0;
         m_act = -1;
      end
      if (hv) begin
         vc = int'(hvc);
         dt = int'(hdt);
         if (hecc) begin
            if (m_ecc < 255) m_ecc++;
            set[0] = 1;
         end else if (vc >= 4) begin
            set[4] = 1;
            if (dt >= 16) m_act = -1;
         end else begin
            if (dt >= 16) m_act = vc;
            if (dt == 0) begin
               if (m_inf[vc]) set[2] = 1;
               m_inf[vc] = 1; m_pkt[vc] = 0; m_lines[vc] = 0; m_ref[vc] = -1;
            end else if (dt == 1) begin
               if (m_inf[vc]) begin
                  if (m_pkt[vc] != 0) set[3] = 1;
                  else begin
                     m_frames[vc] = (m_frames[vc] + 1) % 65536;
                     m_last[vc] = m_lines[vc];
                  end
               end
               m_inf[vc] = 0; m_pkt[vc] = 0;
            end else if ((dt >= 'h18 && dt <= 'h2F) || dt == 'h12) begin
               if (m_inf[vc] && m_pkt[vc] == 0) begin
                  m_pkt[vc] = (dt == 'h12) ? 2 : 1;
                  if (dt != 'h12) begin
                     if (m_ref[vc] < 0) m_ref[vc] = int'(hwc);
                     else if (int'(hwc) != m_ref[vc]) m_wm[vc] = 1;
                  end
               end else set[2] = 1;
            end
         end
      end
      m_st = (m_st & ~clr) | set;
      m_irq = |(m_st & mask);
   endtask

   function automatic snap_t model_snap();
      snap_t s;
      s = '0;
      for (int v = 0; v < 4; v++) begin
         s.fv[v] = m_inf[v];
         s.lv[v] = (m_pkt[v] == 1);
         s.ev[v] = (m_pkt[v] == 2);
         s.wm[v] = m_wm[v];
         s.fc[v*16 +: 16] = 16'(m_frames[v]);
         s.ll[v*16 +: 16] = 16'(m_last[v]);
      end
      s.ecc = 8'(m_ecc);
      s.crc = 8'(m_crc);
      s.st = m_st;
      s.irq = m_irq;
      return s;
   endfunction

   initial begin
      forever begin
         snap_t e;
         snap_t a;
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{fv_o, lv_o, ev_o, wm_o, fc_o, ll_o, ecc_o, crc_o, st_o, irq_o};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL scoreboard cyc %0d: got fv=%h lv=%h ev=%h wm=%h fc=%h ll=%h ecc=%0d crc=%0d st=%b irq=%b, required fv=%h lv=%h ev=%h wm=%h fc=%h ll=%h ecc=%0d crc=%0d st=%b irq=%b",
                        cyc, a.fv, a.lv, a.ev, a.wm, a.fc, a.ll, a.ecc, a.crc, a.st, a.irq,
                        e.fv, e.lv, e.ev, e.wm, e.fc, e.ll, e.ecc, e.crc, e.st, e.irq);
            end
         end
      end
   end

   task automatic tick();
      model_step();
      exp_q.push_back(model_snap());
      @(negedge clk);
      rst = 0; hv = 0; hecc = 0; pv = 0; pcrc = 0; clr = '0;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] req);
      n_chk++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, got, req);
      end
   endtask

   task automatic hdr(input int vc, input logic [5:0] dt, input logic [15:0] wc);
      hv = 1; hvc = 4'(vc); hdt = dt; hwc = wc;
      tick();
   endtask

   task automatic pend(input logic crc);
      pv = 1; pcrc = crc;
      tick();
   endtask

   task automatic line(input int vc, input logic [15:0] wc);
      hdr(vc, 6'h2B, wc);
      tick();
      pend(1'b0);
   endtask

   initial begin
      model_reset();
      rst = 1;
      tick();
      tick();
      chk("reset_frame_cnt", fc_o, 64'h0);
      chk("reset_valids", {48'h0, fv_o, lv_o, ev_o, wm_o}, 64'h0);
      chk("reset_errs", {45'h0, ecc_o, crc_o, st_o, irq_o}, 64'h0);

      hdr(0, 6'h00, 16'd0);
      chk("s1_fv_after_fs", 64'(fv_o[0]), 64'h1);
      for (int i = 0; i < 3; i++) line(0, 16'd1280);
      hdr(0, 6'h01, 16'd0);
      chk("s1_frame_cnt", 64'(fc_o[15:0]), 64'h1);
      chk("s1_last_lines", 64'(ll_o[15:0]), 64'h3);
      chk("s1_fv_low", 64'(fv_o[0]), 64'h0);

      hdr(1, 6'h00, 16'd0);
      hdr(2, 6'h00, 16'd0);
      for (int i = 0; i < 5; i++) begin
         if (i < 2) line(1, 16'd640);
         line(2, 16'd320);
      end
      hdr(1, 6'h01, 16'd0);
      hdr(2, 6'h01, 16'd0);
      chk("s2_last_lines_vc1", 64'(ll_o[31:16]), 64'h2);
      chk("s2_last_lines_vc2", 64'(ll_o[47:32]), 64'h5);
      chk("s2_no_sticky", 64'(st_o), 64'h0);

      hdr(0, 6'h00, 16'd0);
      hdr(0, 6'h2B, 16'd1280);
      hdr(0, 6'h01, 16'd0);
      chk("s3_trunc_sticky", 64'(st_o), 64'h08);
      chk("s3_frame_cnt_kept", 64'(fc_o[15:0]), 64'h1);
      chk("s3_fsm_idle", 64'(fv_o[0]), 64'h0);
      pend(1'b0);
      clr = 5'h1F;
      tick();

      for (int i = 0; i < 300; i++) begin
         hv = 1; hecc = 1;
         hvc = 4'($urandom_range(0, 3));
         hdt = dts[$urandom_range(0, 8)];
         tick();
      end
      chk("s4_ecc_sat", 64'(ecc_o), 64'hFF);
      chk("s4_irq_masked", 64'(irq_o), 64'h0);
      chk("s4_fsm_untouched", {fc_o[15:0], 44'h0, fv_o}, {16'h1, 48'h0});
      mask = 5'b00001;
      tick();
      chk("s4_irq_enabled", 64'(irq_o), 64'h1);
      mask = '0;
      clr = 5'h1F;
      tick();

      hdr(3, 6'h00, 16'd0);
      line(3, 16'd1280);
      line(3, 16'd1276);
      hdr(3, 6'h01, 16'd0);
      chk("s5_wc_mismatch", 64'(wm_o), 64'h8);

      hdr(1, 6'h00, 16'd0);
      hdr(1, 6'h2B, 16'd640);
      pv = 1; pcrc = 1;
      hdr(1, 6'h2B, 16'd640);
      chk("s6_line_valid", 64'(lv_o[1]), 64'h1);
      chk("s6_crc_cnt", 64'(crc_o), 64'h1);
      pend(1'b0);
      hdr(1, 6'h01, 16'd0);
      chk("s6_last_lines", 64'(ll_o[31:16]), 64'h2);

      hdr(5, 6'h00, 16'd0);
      chk("s7_unsup_vc", 64'(st_o[4]), 64'h1);

      hdr(0, 6'h00, 16'd0);
      hdr(0, 6'h2B, 16'd1280);
      rst = 1;
      tick();
      chk("s8_reset_cnts", fc_o | ll_o, 64'h0);
      chk("s8_reset_flags", {45'h0, fv_o, lv_o, ev_o, wm_o, st_o, irq_o}, 64'h0);
      chk("s8_reset_errcnt", {48'h0, ecc_o, crc_o}, 64'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 55) begin
            hv = 1;
            if ($urandom_range(0, 9) == 0) hvc = 4'(4 + $urandom_range(0, 11));
            else hvc = 4'($urandom_range(0, 3));
            hdt = dts[$urandom_range(0, 8)];
            hwc = ($urandom_range(0, 3) == 0) ? 16'd1276 : 16'd1280;
            hecc = ($urandom_range(0, 19) == 0);
         end
         if ($urandom_range(0, 2) == 0) begin
            pv = 1;
            pcrc = ($urandom_range(0, 4) == 0);
         end
         if ($urandom_range(0, 9) == 0) clr = 5'($urandom);
         if ($urandom_range(0, 49) == 0) mask = 5'($urandom);
         if ($urandom_range(0, 999) == 0) rst = 1;
         tick();
      end

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expected snapshots left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
